// File: rtl/fir_64_mdc_ctrl_fsm_if.sv
// Streamer-side handshake bundle of the fir_64_mdc job sequencer.
// master = sequencer, slave = x_V source / y_V sink.
interface fir_64_mdc_ctrl_fsm_if #(
   parameter int unsigned CNT_W = 16
);
   logic             src_ready_i;
   logic             snk_ready_i;
   logic             src_done_i;
   logic             snk_done_i;
   logic             src_req_start_o;
   logic             snk_req_start_o;
   logic [31:0]      src_addr_o;
   logic [31:0]      snk_addr_o;
   logic [CNT_W-1:0] trans_size_o;

   modport master (
      input  src_ready_i,
      input  snk_ready_i,
      input  src_done_i,
      input  snk_done_i,
      output src_req_start_o,
      output snk_req_start_o,
      output src_addr_o,
      output snk_addr_o,
      output trans_size_o
   );

   modport slave (
      output src_ready_i,
      output snk_ready_i,
      output src_done_i,
      output snk_done_i,
      input  src_req_start_o,
      input  snk_req_start_o,
      input  src_addr_o,
      input  snk_addr_o,
      input  trans_size_o
   );
endinterface

// File: rtl/fir_64_mdc_ctrl_fsm.sv
// Job sequencer for the fir_64_mdc streamer: latches a job, starts
// x_V and y_V together, waits for both, then pulses done.
module fir_64_mdc_ctrl_fsm #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             start_i,
   input  logic [31:0]      x_addr_i,
   input  logic [31:0]      y_addr_i,
   input  logic [CNT_W-1:0] n_samples_i,
   fir_64_mdc_ctrl_fsm_if.master strm,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [31:0]      run_cycles_o
);

   localparam logic [31:0] TO     = 32'(TIMEOUT);
   localparam logic [31:0] CNTMAX = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_RUN,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [31:0]      xa_q, xa_d;
   logic [31:0]      ya_q, ya_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic [31:0]      cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             sdn_q, sdn_d;
   logic             kdn_q, kdn_d;
   logic             req;
   logic [31:0]      cnt_inc;

   assign cnt_inc = (cnt_q == CNTMAX) ? cnt_q : cnt_q + 32'd1;

   always_comb begin
      state_d = state_q;
      xa_d    = xa_q;
      ya_d    = ya_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      sdn_d   = sdn_q;
      kdn_d   = kdn_q;
      req     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               xa_d    = x_addr_i;
               ya_d    = y_addr_i;
               n_d     = n_samples_i;
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = (n_samples_i == '0) ? S_DONE : S_ARM;
            end
         end
         S_ARM: begin
            if (strm.src_ready_i && strm.snk_ready_i) begin
               req     = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            cnt_d = cnt_inc;
            sdn_d = sdn_q | strm.src_done_i;
            kdn_d = kdn_q | strm.snk_done_i;
            // completion wins over a watchdog hit in the same cycle
            if (sdn_d && kdn_d) begin
               state_d = S_DONE;
            end else if (TIMEOUT != 0 && cnt_inc >= TO) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            sdn_d   = 1'b0;
            kdn_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (clear_i) begin
         state_d = S_IDLE;
         xa_d    = '0;
         ya_d    = '0;
         n_d     = '0;
         cnt_d   = '0;
         err_d   = 1'b0;
         sdn_d   = 1'b0;
         kdn_d   = 1'b0;
         req     = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         xa_q    <= '0;
         ya_q    <= '0;
         n_q     <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         sdn_q   <= 1'b0;
         kdn_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         xa_q    <= xa_d;
         ya_q    <= ya_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         sdn_q   <= sdn_d;
         kdn_q   <= kdn_d;
      end
   end

   assign strm.src_req_start_o = req;
   assign strm.snk_req_start_o = req;
   assign strm.src_addr_o      = xa_q;
   assign strm.snk_addr_o      = ya_q;
   assign strm.trans_size_o    = n_q;
   assign busy_o               = (state_q != S_IDLE);
   assign done_o               = (state_q == S_DONE);
   assign err_o                = err_q;
   assign run_cycles_o         = cnt_q;

endmodule
